result_reader: RTL and testbench
================================

RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 8: number of result words to drain.
REQ-002 SHALL have parameter MEM_WIDTH, default 32: result word width in bits.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start_i  input  1  request to drain the result memory, sampled only in IDLE.
REQ-006 SHALL have port mem_addr_o  output  $clog2(MEM_DEPTH)  read address to the result memory.
REQ-007 SHALL have port mem_rdata_i  input  MEM_WIDTH  read data; valid one cycle after mem_addr_o is presented.
REQ-008 SHALL have port data_o  output  MEM_WIDTH  streamed result word.
REQ-009 SHALL have port index_o  output  $clog2(MEM_DEPTH)  memory index of data_o.
REQ-010 SHALL have port data_valid_o  output  1  data_o/index_o valid.
REQ-011 SHALL have port data_ready_i  input  1  consumer accepts the word when high with data_valid_o.
REQ-012 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse after the last word is accepted.
REQ-014 SHALL have port checksum_o  output  MEM_WIDTH  running sum of accepted words (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, SEND, DONE.
REQ-016 IDLE -> FETCH on start_i=1, with the index counter cleared to 0; otherwise SHALL stay in IDLE.
REQ-017 FETCH SHALL drive mem_addr_o = index counter and SHALL go to WAIT unconditionally.
REQ-018 WAIT SHALL capture mem_rdata_i into the data_o register and the index into index_o, then go to SEND.
REQ-019 SEND SHALL hold data_valid_o=1 and SHALL keep data_o and index_o stable until data_ready_i=1.
REQ-020 On acceptance in SEND, if index = MEM_DEPTH-1 the FSM SHALL go to DONE; otherwise it SHALL increment the index and go to FETCH.
REQ-021 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-022 data_valid_o SHALL rise at the second rising edge after the edge that sampled start_i (FETCH, WAIT, SEND).
REQ-023 Maximum throughput SHALL be one word per 3 cycles with data_ready_i held high.
REQ-024 start_i SHALL be ignored while busy_o=1 and SHALL NOT restart or disturb the drain.
REQ-025 data_ready_i SHALL be ignored when data_valid_o=0.
REQ-026 The index SHALL never exceed MEM_DEPTH-1 and SHALL NOT wrap during a drain.
REQ-027 mem_addr_o SHALL hold its last value outside FETCH.
REQ-028 start_i sampled in the cycle DONE is active SHALL be ignored, and a new drain SHALL begin only from IDLE.

Reset
REQ-029 On rst_ni=0 the FSM SHALL enter IDLE immediately, regardless of the clock.
REQ-030 During reset, data_valid_o, done_o, busy_o, mem_addr_o, index_o, data_o and checksum_o SHALL all be 0.
REQ-031 Reset during a drain SHALL abort it, drop data_valid_o without acceptance and leave no pending word.

Configuration
REQ-032 When RESULT_READER_CHECKSUM_EN is defined, checksum_o SHALL clear to 0 when start_i is accepted and SHALL add each accepted word modulo 2^MEM_WIDTH; its value is final when done_o=1.
REQ-033 When RESULT_READER_CHECKSUM_EN is not defined, checksum_o SHALL be constant 0 and SHALL contain no accumulator logic.

Verification
REQ-034 Memory holds 5,3,-1,7,0,2,9,4 and data_ready_i=1; pulse start_i -> 8 words stream in index order 0..7 with those values; done_o pulses once; checksum_o=29 (macro on).
REQ-035 data_ready_i=0 for 10 cycles while word 2 is valid -> data_o and index_o stay at 2's value for all 10 cycles; stream then continues with no loss or duplication.
REQ-036 start_i held high through the whole drain -> exactly one drain of 8 words, then a second drain starts from IDLE after done_o.
REQ-037 rst_ni low while word 4 is valid -> all outputs are 0 in the same cycle; after release with start_i=0, busy_o stays 0.
REQ-038 Start edge at cycle k -> mem_addr_o=0 in cycle k+1 and data_valid_o=1 from cycle k+3; busy_o=1 from cycle k+1 until done_o.
REQ-039 Memory holds 0xFFFFFFFF in all 8 words (macro on) -> checksum_o=0xFFFFFFF8 (modulo wrap); with the macro off, checksum_o=0 throughout.

Source files
------------

// File: rtl/result_reader.sv
// Drains MEM_DEPTH words from a synchronous-read result memory and streams them out with valid/ready.
// Define RESULT_READER_CHECKSUM_EN to get a running modulo-2^MEM_WIDTH sum of accepted words on checksum_o.
module result_reader #(
    parameter int MEM_DEPTH = 8,
    parameter int MEM_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
    input  logic [MEM_WIDTH-1:0]         mem_rdata_i,
    output logic [MEM_WIDTH-1:0]         data_o,
    output logic [$clog2(MEM_DEPTH)-1:0] index_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [MEM_WIDTH-1:0]         checksum_o
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [AW-1:0]        r_idx;
    logic [AW-1:0]        r_mem_addr;
    logic [AW-1:0]        r_index;
    logic [MEM_WIDTH-1:0] r_data;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_last;

    assign w_start  = (r_state == S_IDLE) && start_i;
    assign w_accept = (r_state == S_SEND) && data_ready_i;
    assign w_last   = (r_idx == LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_FETCH;
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  w_next = S_SEND;
            S_SEND:  if (data_ready_i) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The address register is loaded on entry to FETCH so it equals the index there and holds elsewhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_index    <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_idx      <= '0;
                r_mem_addr <= '0;
            end
            if (r_state == S_WAIT) begin
                r_data  <= mem_rdata_i;
                r_index <= r_idx;
            end
            if (w_accept && !w_last) begin
                r_idx      <= r_idx + 1'b1;
                r_mem_addr <= r_idx + 1'b1;
            end
        end
    end

`ifdef RESULT_READER_CHECKSUM_EN
    logic [MEM_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = '0;
`endif

    assign mem_addr_o   = r_mem_addr;
    assign data_o       = r_data;
    assign index_o      = r_index;
    assign data_valid_o = (r_state == S_SEND);
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: a synchronous-read memory model feeds the DUT and every streamed word is checked.
module tb_result_reader;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             start = 1'b0;
    logic             ready = 1'b0;
    logic [2:0]       memAddr;
    logic [WIDTH-1:0] memRdata;
    logic [WIDTH-1:0] dataOut;
    logic [2:0]       indexOut;
    logic             dataValid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    result_reader #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .start_i     (start),
        .mem_addr_o  (memAddr),
        .mem_rdata_i (memRdata),
        .data_o      (dataOut),
        .index_o     (indexOut),
        .data_valid_o(dataValid),
        .data_ready_i(ready),
        .busy_o      (busy),
        .done_o      (done),
        .checksum_o  (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) memRdata <= mem[memAddr];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] expectedChecksum(input logic [WIDTH-1:0] sum);
`ifdef RESULT_READER_CHECKSUM_EN
        return sum;
`else
        return '0;
`endif
    endfunction

    task automatic applyStimulus(input logic startLevel);
        @(negedge clk);
        start = startLevel;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, dataValid, 0);
        checkOutput({tag, ".done"}, done, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".addr"}, memAddr, 0);
        checkOutput({tag, ".index"}, indexOut, 0);
        checkOutput({tag, ".data"}, dataOut, 0);
        checkOutput({tag, ".checksum"}, checksum, 0);
    endtask

    // Walks one drain to its done pulse, checking each word; the consumer stalls stallCycles on stallWord.
    task automatic collectDrain(input int stallWord, input int stallCycles,
                                output int words, output int firstOff, output int span);
        int expIdx = 0;
        int stallLeft = stallCycles;
        int cyc = 0;
        int lastCyc = 0;
        bit finished = 0;
        logic [WIDTH-1:0] sum = '0;
        firstOff = -1;
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (dataValid) begin
                if (firstOff < 0) firstOff = cyc;
                lastCyc = cyc;
                if (expIdx < DEPTH) begin
                    checkOutput("word.data", dataOut, mem[expIdx]);
                    checkOutput("word.index", indexOut, expIdx);
                    checkOutput("word.addrHold", memAddr, expIdx);
                    checkOutput("word.busy", busy, 1);
                    if (expIdx == stallWord && stallLeft > 0) begin
                        ready = 1'b0;
                        stallLeft--;
                    end else begin
                        ready = 1'b1;
                        sum += mem[expIdx];
                        expIdx++;
                    end
                end else begin
                    checkOutput("extraWord", expIdx, DEPTH - 1);
                    ready = 1'b1;
                end
            end else begin
                ready = 1'b1;
            end
            if (done) begin
                checkOutput("done.checksum", checksum, expectedChecksum(sum));
                checkOutput("done.noValid", dataValid, 0);
                finished = 1;
            end
        end
        checkOutput("doneSeen", finished, 1);
        words = expIdx;
        span = lastCyc - firstOff;
        @(negedge clk);
        checkOutput("afterDone.done", done, 0);
        checkOutput("afterDone.busy", busy, 0);
    endtask

    initial begin
        int words, firstOff, span;
        bit found;

        mem = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd2, 32'd9, 32'd4};

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        ready = 1'b1;

        $display("[TB] basic drain with ready held high");
        applyStimulus(1'b1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("k1.busy", busy, 1);
        checkOutput("k1.addr", memAddr, 0);
        checkOutput("k1.valid", dataValid, 0);
        collectDrain(-1, 0, words, firstOff, span);
        checkOutput("basic.words", words, 8);
        checkOutput("basic.firstValid", firstOff, 2);
        checkOutput("basic.span", span, 21);

        $display("[TB] consumer stall on word 2");
        applyStimulus(1'b1);
        @(negedge clk);
        start = 1'b0;
        collectDrain(2, 10, words, firstOff, span);
        checkOutput("stall.words", words, 8);
        checkOutput("stall.span", span, 31);

        $display("[TB] start held through the drain");
        applyStimulus(1'b1);
        collectDrain(-1, 0, words, firstOff, span);
        checkOutput("hold.words", words, 8);
        @(negedge clk);
        checkOutput("hold.restartBusy", busy, 1);
        checkOutput("hold.restartAddr", memAddr, 0);
        checkOutput("hold.restartValid", dataValid, 0);
        start = 1'b0;
        collectDrain(-1, 0, words, firstOff, span);
        checkOutput("hold.secondWords", words, 8);

        $display("[TB] reset while word 4 is valid");
        applyStimulus(1'b1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dataValid && indexOut == 3'd4) found = 1;
        end
        checkOutput("word4Seen", found, 1);
        ready = 1'b0;
        #2 rstN = 1'b0;
        #1 checkAllZero("midReset");
        @(negedge clk);
        rstN = 1'b1;
        ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("postReset.busy", busy, 0);
        checkOutput("postReset.valid", dataValid, 0);
        applyStimulus(1'b1);
        @(negedge clk);
        start = 1'b0;
        collectDrain(-1, 0, words, firstOff, span);
        checkOutput("postReset.words", words, 8);

        $display("[TB] all-ones memory for checksum wrap");
        mem = '{default: 32'hFFFF_FFFF};
        applyStimulus(1'b1);
        @(negedge clk);
        start = 1'b0;
        collectDrain(-1, 0, words, firstOff, span);
        checkOutput("ones.words", words, 8);
`ifdef RESULT_READER_CHECKSUM_EN
        checkOutput("ones.checksumHeld", checksum, 32'hFFFF_FFF8);
`else
        checkOutput("ones.checksumZero", checksum, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
